// File: rtl/shake_ctrl.sv
// Sequencing controller for a SHAKE128/SHAKE256 Keccak datapath.
// Issues absorb/permute/squeeze strobes and lane/round indices; holds no state data.
module shake_ctrl #(
  parameter int N_ROUNDS = 24,
  parameter int LEN_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode,
  input  logic [LEN_W-1:0] out_len,
  input  logic             abort,
  input  logic             in_valid,
  input  logic             in_last,
  output logic             in_ready,
  output logic             absorb_en,
  output logic [4:0]       absorb_idx,
  output logic [4:0]       squeeze_idx,
  output logic             perm_en,
  output logic [4:0]       round_idx,
  output logic             clear_state,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             done,
  output logic             error
);

  localparam logic [4:0] RATE128_MAX = 5'd20;
  localparam logic [4:0] RATE256_MAX = 5'd16;
  localparam logic [4:0] ROUND_MAX   = 5'(N_ROUNDS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ABSORB,
    S_PERMUTE,
    S_SQUEEZE,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic             mode_q, mode_d;
  logic [4:0]       word_cnt_q, word_cnt_d;
  logic [4:0]       round_cnt_q, round_cnt_d;
  logic [LEN_W-1:0] remaining_q, remaining_d;
  logic             last_seen_q, last_seen_d;
  logic             error_q, error_d;
  logic [4:0]       rate_max;

  assign rate_max = mode_q ? RATE256_MAX : RATE128_MAX;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      mode_q      <= 1'b0;
      word_cnt_q  <= '0;
      round_cnt_q <= '0;
      remaining_q <= '0;
      last_seen_q <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      // NOTE: non-blocking so every register updates from the same pre-edge values.
      state_q     <= state_d;
      mode_q      <= mode_d;
      word_cnt_q  <= word_cnt_d;
      round_cnt_q <= round_cnt_d;
      remaining_q <= remaining_d;
      last_seen_q <= last_seen_d;
      error_q     <= error_d;
    end
  end

  always_comb begin
    // NOTE: every signal gets a default first so no path can infer a latch.
    state_d     = state_q;
    mode_d      = mode_q;
    word_cnt_d  = word_cnt_q;
    round_cnt_d = round_cnt_q;
    remaining_d = remaining_q;
    last_seen_d = last_seen_q;
    error_d     = error_q;
    in_ready    = 1'b0;
    absorb_en   = 1'b0;
    absorb_idx  = '0;
    squeeze_idx = '0;
    perm_en     = 1'b0;
    round_idx   = '0;
    clear_state = 1'b0;
    out_valid   = 1'b0;
    done        = 1'b0;

    if (state_q != S_IDLE && abort) begin
      // Abort wins over everything: strobes stay low and error is untouched.
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          // Gated by rst so nothing leaks out while the block is held in reset.
          clear_state = start && !abort && rst;
          if (start && !abort) begin
            mode_d      = mode;
            remaining_d = out_len;
            word_cnt_d  = '0;
            round_cnt_d = '0;
            last_seen_d = 1'b0;
            error_d     = 1'b0;
            state_d     = S_ABSORB;
          end
        end

        S_ABSORB: begin
          in_ready   = 1'b1;
          absorb_idx = word_cnt_q;
          absorb_en  = in_valid;
          if (in_valid) begin
            if (word_cnt_q == rate_max) begin
              word_cnt_d  = '0;
              last_seen_d = in_last;
              state_d     = S_PERMUTE;
            end else begin
              word_cnt_d = word_cnt_q + 5'd1;
              if (in_last) begin
                // Padding upstream guarantees in_last only on the final rate lane.
                error_d = 1'b1;
                state_d = S_IDLE;
              end
            end
          end
        end

        S_PERMUTE: begin
          perm_en   = 1'b1;
          round_idx = round_cnt_q;
          if (round_cnt_q == ROUND_MAX) begin
            round_cnt_d = '0;
            if (!last_seen_q)            state_d = S_ABSORB;
            else if (remaining_q == '0)  state_d = S_DONE;
            else                         state_d = S_SQUEEZE;
          end else begin
            round_cnt_d = round_cnt_q + 5'd1;
          end
        end

        S_SQUEEZE: begin
          out_valid   = 1'b1;
          squeeze_idx = word_cnt_q;
          if (out_ready) begin
            remaining_d = remaining_q - LEN_W'(1);
            word_cnt_d  = (word_cnt_q == rate_max) ? 5'd0 : word_cnt_q + 5'd1;
            if (remaining_q == LEN_W'(1))    state_d = S_DONE;
            else if (word_cnt_q == rate_max) state_d = S_PERMUTE;
          end
        end

        S_DONE: begin
          done    = 1'b1;
          state_d = S_IDLE;
        end

        default: state_d = S_IDLE;
      endcase
    end
  end

  assign busy  = (state_q != S_IDLE);
  assign error = error_q;

endmodule

// File: tb/tb_shake_ctrl.sv
// Directed self-checking bench for shake_ctrl: cycle-exact SHAKE128 run, stalled
// multi-block SHAKE256 run, protocol error, zero-length output, abort and reset.
module tb_shake_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, mode, abort;
  logic [15:0] out_len;
  logic        in_valid, in_last, in_ready, absorb_en;
  logic [4:0]  absorb_idx, squeeze_idx, round_idx;
  logic        perm_en, clear_state, out_valid, out_ready;
  logic        busy, done, error;

  int checks   = 0;
  int errors   = 0;
  int done_cnt = 0;
  int done_base;

  shake_ctrl #(.N_ROUNDS(24), .LEN_W(16)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .out_len(out_len),
    .abort(abort), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
    .absorb_en(absorb_en), .absorb_idx(absorb_idx), .squeeze_idx(squeeze_idx),
    .perm_en(perm_en), .round_idx(round_idx), .clear_state(clear_state),
    .out_valid(out_valid), .out_ready(out_ready), .busy(busy), .done(done),
    .error(error)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (done) done_cnt++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Feeds `rate` words, optionally with random valid gaps; idx must hold during gaps.
  task automatic absorb_words(input int rate, input bit last, input bit stall);
    int w;
    int guard;
    w = 0;
    guard = 0;
    while (w < rate && guard < 400) begin
      in_valid = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
      in_last  = last && (w == rate - 1);
      #1;
      check($sformatf("in_ready w%0d", w), in_ready, 1);
      check($sformatf("absorb_en w%0d", w), absorb_en, in_valid);
      check($sformatf("absorb_idx w%0d", w), absorb_idx, w);
      check($sformatf("perm_en_abs w%0d", w), perm_en, 0);
      if (in_valid) w++;
      tick();
      guard++;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    check("absorb_words_bound", w, rate);
  endtask

  task automatic permute_rounds();
    for (int r = 0; r < 24; r++) begin
      #1;
      check($sformatf("perm_en r%0d", r), perm_en, 1);
      check($sformatf("round_idx r%0d", r), round_idx, r);
      check($sformatf("out_valid_perm r%0d", r), out_valid, 0);
      check($sformatf("in_ready_perm r%0d", r), in_ready, 0);
      tick();
    end
  endtask

  task automatic squeeze_words(input int n, input bit stall);
    int k;
    int guard;
    k = 0;
    guard = 0;
    while (k < n && guard < 400) begin
      out_ready = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
      #1;
      check($sformatf("out_valid k%0d", k), out_valid, 1);
      check($sformatf("squeeze_idx k%0d", k), squeeze_idx, k);
      check($sformatf("perm_en_sq k%0d", k), perm_en, 0);
      if (out_ready) k++;
      tick();
      guard++;
    end
    out_ready = 1'b0;
    check("squeeze_words_bound", k, n);
  endtask

  task automatic do_start(input logic m, input logic [15:0] len);
    start   = 1'b1;
    mode    = m;
    out_len = len;
    #1;
    check("clear_state_on_start", clear_state, 1);
    check("busy_idle_at_start", busy, 0);
    tick();
    start = 1'b0;
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; mode = 1'b0; abort = 1'b0; out_len = '0;
    in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
    #2;
    check("rst_busy", busy, 0);
    check("rst_error", error, 0);
    check("rst_done", done, 0);
    check("rst_in_ready", in_ready, 0);
    @(negedge clk);
    rst = 1'b1;
    tick();

    // start together with abort in IDLE is ignored
    start = 1'b1; abort = 1'b1;
    #1;
    check("start_abort_clear", clear_state, 0);
    tick();
    start = 1'b0; abort = 1'b0;
    #1;
    check("start_abort_busy", busy, 0);
    tick();

    // 1: SHAKE128 single block, out_len 2, no stalls (cycles 0..48)
    done_base = done_cnt;
    do_start(1'b0, 16'd2);
    absorb_words(21, 1'b1, 1'b0);
    permute_rounds();
    squeeze_words(2, 1'b0);
    #1;
    check("t1_done_c48", done, 1);
    check("t1_busy_c48", busy, 1);
    check("t1_out_valid_c48", out_valid, 0);
    tick();
    #1;
    check("t1_done_clear", done, 0);
    check("t1_busy_end", busy, 0);
    check("t1_done_pulses", done_cnt - done_base, 1);
    tick();

    // 2: SHAKE256, 2 blocks, stalls both sides, out_len 20 -> 17 + re-permute + 3
    done_base = done_cnt;
    do_start(1'b1, 16'd20);
    absorb_words(17, 1'b0, 1'b1);
    permute_rounds();
    absorb_words(17, 1'b1, 1'b1);
    permute_rounds();
    squeeze_words(17, 1'b1);
    permute_rounds();
    squeeze_words(3, 1'b1);
    #1;
    check("t2_done", done, 1);
    tick();
    #1;
    check("t2_busy_end", busy, 0);
    check("t2_done_pulses", done_cnt - done_base, 1);
    tick();

    // 3: in_last at word 5 of a SHAKE128 block -> error, IDLE, no done
    done_base = done_cnt;
    do_start(1'b0, 16'd4);
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1;
      in_last  = (i == 5);
      tick();
    end
    in_valid = 1'b0; in_last = 1'b0;
    #1;
    check("t3_error_set", error, 1);
    check("t3_busy_idle", busy, 0);
    check("t3_no_done", done_cnt - done_base, 0);
    tick();
    start = 1'b1; mode = 1'b0; out_len = 16'd1;
    #1;
    check("t3_error_held_at_start", error, 1);
    tick();
    start = 1'b0;
    #1;
    check("t3_error_cleared", error, 0);
    check("t3_busy_after_start", busy, 1);
    in_valid = 1'b1; abort = 1'b1;
    #1;
    check("t3_abort_in_ready", in_ready, 0);
    check("t3_abort_absorb_en", absorb_en, 0);
    tick();
    abort = 1'b0; in_valid = 1'b0;
    #1;
    check("t3_abort_busy", busy, 0);
    check("t3_abort_error_kept", error, 0);
    tick();

    // 4: out_len 0 -> no output words, done right after round 23
    done_base = done_cnt;
    do_start(1'b0, 16'd0);
    absorb_words(21, 1'b1, 1'b0);
    permute_rounds();
    #1;
    check("t4_done", done, 1);
    check("t4_out_valid", out_valid, 0);
    tick();
    #1;
    check("t4_busy_end", busy, 0);
    check("t4_done_pulses", done_cnt - done_base, 1);
    tick();

    // 5: abort during PERMUTE at round 10, then a fresh normal run
    do_start(1'b0, 16'd1);
    absorb_words(21, 1'b1, 1'b0);
    for (int r = 0; r < 10; r++) tick();
    #1;
    check("t5_round10", round_idx, 10);
    abort = 1'b1;
    #1;
    check("t5_abort_perm_en", perm_en, 0);
    tick();
    abort = 1'b0;
    #1;
    check("t5_busy_after_abort", busy, 0);
    check("t5_perm_en_after_abort", perm_en, 0);
    tick();
    done_base = done_cnt;
    do_start(1'b0, 16'd1);
    absorb_words(21, 1'b1, 1'b0);
    permute_rounds();
    squeeze_words(1, 1'b0);
    #1;
    check("t5_done", done, 1);
    tick();
    #1;
    check("t5_done_pulses", done_cnt - done_base, 1);
    tick();

    // 6: reset asserted mid-SQUEEZE clears all outputs asynchronously
    do_start(1'b1, 16'd5);
    absorb_words(17, 1'b1, 1'b0);
    permute_rounds();
    squeeze_words(2, 1'b0);
    #1;
    check("t6_squeezing", out_valid, 1);
    check("t6_squeeze_idx", squeeze_idx, 2);
    start = 1'b1;
    rst   = 1'b0;
    #1;
    check("t6_rst_out_valid", out_valid, 0);
    check("t6_rst_busy", busy, 0);
    check("t6_rst_squeeze_idx", squeeze_idx, 0);
    check("t6_rst_clear_state", clear_state, 0);
    check("t6_rst_done", done, 0);
    check("t6_rst_error", error, 0);
    tick();
    rst = 1'b1; start = 1'b0;
    #1;
    check("t6_release_busy", busy, 0);
    check("t6_release_out_valid", out_valid, 0);
    tick();
    #1;
    check("t6_idle_stays", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/shake_ctrl.md
# shake_ctrl

Sequencing controller for the SHAKE128/SHAKE256 core. It drives the external Keccak state datapath (absorb XOR, round logic, squeeze mux) through absorb, permute and squeeze phases, with valid/ready handshakes on the input and output word streams. Its internal round and word counters follow the team's wrap-at-max counter style. The block holds no state data; it issues strobes and indices only.

## Interface
- N_ROUNDS, 24: permutation rounds per block.
- LEN_W, 16: width of the output length field (in words).
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- start  in  1  begin a new hash. Sampled only in IDLE.
- mode  in  1  0 = SHAKE128 (RATE = 21 words), 1 = SHAKE256 (RATE = 17 words). Latched on start.
- out_len  in  LEN_W  number of 64-bit output words. Latched on start.
- abort  in  1  synchronous abort. Returns the block to IDLE.
- in_valid, in_last  in  1  input word strobe and final-word marker. Input is pre-padded upstream.
- in_ready  out  1  controller accepts an input word.
- absorb_en  out  1  XOR the input word into the state lane at absorb_idx.
- absorb_idx, squeeze_idx  out  5  rate-lane index.
- perm_en  out  1  apply one round.
- round_idx  out  5  round constant index.
- clear_state  out  1  zero the state.
- out_valid  out  1  lane at squeeze_idx is valid output.
- out_ready  in  1  downstream accepts the output word.
- busy  out  1  state != IDLE.
- done  out  1  one-cycle completion pulse.
- error  out  1  sticky protocol error. Cleared on the next accepted start.

## Operation
- States: IDLE, ABSORB, PERMUTE, SQUEEZE, DONE.
- Counters:
  - word_cnt is 5 bits and wraps to 0 after RATE-1.
  - round_cnt is 5 bits and wraps to 0 after N_ROUNDS-1.
  - remaining is LEN_W bits.
  - A last_seen flag records that the final input word has been accepted.
- IDLE: clear_state = start (combinational). On start:
  - latch mode and out_len;
  - load remaining = out_len;
  - clear word_cnt, round_cnt, last_seen and error;
  - go to ABSORB.
- ABSORB:
  - in_ready = 1, absorb_idx = word_cnt, absorb_en = in_valid.
  - Each accepted word increments word_cnt.
  - On acceptance at word_cnt = RATE-1: go to PERMUTE and set last_seen = in_last.
  - in_last accepted at word_cnt != RATE-1: set error and go to IDLE. No done pulse is issued.
- PERMUTE: perm_en = 1 and round_idx = round_cnt, one round per cycle. After round N_ROUNDS-1:
  - if last_seen = 0, go to ABSORB;
  - else if remaining = 0, go to DONE;
  - else go to SQUEEZE.
- SQUEEZE:
  - out_valid = 1, squeeze_idx = word_cnt.
  - On out_ready: decrement remaining and increment word_cnt.
  - If the new remaining = 0, go to DONE.
  - Else if word_cnt was RATE-1, go to PERMUTE (re-squeeze), with word_cnt wrapping to 0.
- DONE: done = 1 for one cycle, then go to IDLE.
- out_len = 0 is legal: absorb and permute run, then DONE, with no output words.
- abort in any non-IDLE state: next state is IDLE. All strobes are deasserted in that cycle; error is unchanged.
- abort has priority over every other transition. start together with abort in IDLE is ignored.

## Timing
- Reset (rst = 0), asynchronous:
  - state = IDLE;
  - all counters = 0;
  - every output = 0, including error and busy.
- rst deasserted mid-operation starts from IDLE. No partial-state recovery.
- Strobes (in_ready, absorb_en, perm_en, out_valid, clear_state) are combinational from the registered state, counters and inputs. No extra latency.
- Input stalls (in_valid = 0) and output stalls (out_ready = 0) hold all counters. Outputs are stable while stalled.
- Single-block SHAKE128 with continuous input and out_len = 2, taking the start cycle as 0:
  - cycle 0: clear_state;
  - cycles 1-21: absorb;
  - cycles 22-45: PERMUTE;
  - cycles 46-47: SQUEEZE;
  - cycle 48: done.
- A re-squeeze adds N_ROUNDS cycles after each RATE output words.

## Test plan
- SHAKE128, 1 block, out_len = 2, no stalls:
  - clear_state at cycle 0, absorb_idx 0..20 at cycles 1-21;
  - round_idx 0..23 at cycles 22-45;
  - out_valid at 46-47 with squeeze_idx 0,1;
  - done at cycle 48.
- SHAKE256, 2 blocks, random in_valid/out_ready stalls, out_len = 20:
  - two permutes between absorb phases;
  - 17 outputs, then re-permute, then 3 outputs with squeeze_idx 0..2;
  - exactly one done pulse.
- in_last at word 5 of a SHAKE128 block -> error = 1 next cycle, state IDLE, no done. A subsequent start clears error.
- out_len = 0 -> no out_valid ever; done exactly 1 cycle after round 23.
- abort during PERMUTE at round 10 -> busy = 0 next cycle, perm_en = 0. A fresh start then runs the normal sequence.
- rst pulled low mid-SQUEEZE -> all outputs 0 asynchronously, state IDLE after release.
